escaner_teclado: RTL and testbench

Parametrised matrix-keypad scanner; successor to the combinational 4x4 row/column-to-key comparator. It drives the column lines one-hot in rotation, samples the row lines, debounces across whole scan frames and rejects multi-key presses. It reports one key code per press with a single-cycle strobe. It sits between the keypad pins (after the row synchronisers) and the display/control logic.

---
 rtl/escaner_teclado.sv | 249 ++++++++++++++++++++++++
 tb/tb_escaner_teclado.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/escaner_teclado.sv
`default_nettype none
// ============================================================================
// Module      : escaner_teclado
// Description : Matrix keypad scanner. Drives the columns one-hot in
//               rotation, samples the rows, debounces over whole scan frames,
//               rejects ghosting/multi-key presses and reports one key code
//               per accepted press with a single-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module escaner_teclado #(
    parameter int N_FIL    = 4,
    parameter int N_COL    = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4,
    parameter int MODO     = 0,
    localparam int KW      = (N_FIL * N_COL > 1) ? $clog2(N_FIL * N_COL) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_FIL-1:0] fil,
    output logic [N_COL-1:0] col,
    output logic [KW-1:0]    tecla,
    output logic             valida,
    output logic             presionada
);

    localparam int c_DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_CW = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int c_RW = (N_FIL > 1) ? $clog2(N_FIL) : 1;
    localparam int c_BW = $clog2(DEBOUNCE + 1);

    localparam logic [N_COL-1:0] c_COL_FIRST = N_COL'(1) << (N_COL - 1);

    localparam logic [1:0] c_REPOSO   = 2'd0;
    localparam logic [1:0] c_CONFIRMA = 2'd1;
    localparam logic [1:0] c_PULSADA  = 2'd2;

    logic [c_DW-1:0]  r_div;
    logic [N_COL-1:0] r_col;
    logic [1:0]       r_hits;
    logic [c_CW-1:0]  r_hc;
    logic [c_RW-1:0]  r_hr;
    logic [1:0]       r_state;
    logic [KW-1:0]    r_cand;
    logic [c_BW-1:0]  r_cnt;
    logic [c_BW-1:0]  r_rel;
    logic [KW-1:0]    r_tecla;
    logic             r_valida;
    logic             r_pres;

    logic             w_tc;
    logic             w_fe;
    logic             w_onehot;
    logic [c_CW-1:0]  w_cidx;
    logic [c_RW-1:0]  w_row;
    logic [1:0]       w_base;
    logic [1:0]       w_hits;
    logic [c_CW-1:0]  w_kc;
    logic [c_RW-1:0]  w_kr;
    logic             w_key;
    logic [KW-1:0]    w_code;
    logic [1:0]       w_state_n;
    logic [KW-1:0]    w_cand_n;
    logic [c_BW-1:0]  w_cnt_n;
    logic [c_BW-1:0]  w_rel_n;
    logic [c_BW-1:0]  w_cnt_inc;
    logic [c_BW-1:0]  w_rel_inc;
    logic [KW-1:0]    w_tecla_n;
    logic             w_valida_n;
    logic             w_pres_n;

    assign w_tc     = (r_div == c_DW'(SCAN_DIV - 1));
    assign w_fe     = w_tc && (w_cidx == c_CW'(N_COL - 1));
    assign w_onehot = (fil != '0) && ((fil & (fil - N_FIL'(1))) == '0);
    assign w_key    = (w_hits == 2'd1);

    // Dwell counter and column rotation; column advances right after its sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_col <= c_COL_FIRST;
        end else if (w_tc) begin
            r_div <= '0;
            r_col <= {r_col[0], r_col[N_COL-1:1]};
        end else begin
            r_div <= r_div + c_DW'(1);
        end
    end

    // Column index (0 = MSB) and row index of the single active row.
    always_comb begin
        w_cidx = '0;
        w_row  = '0;
        for (int i = 0; i < N_COL; i++)
            if (r_col[N_COL-1-i]) w_cidx = c_CW'(i);
        for (int i = 0; i < N_FIL; i++)
            if (fil[N_FIL-1-i]) w_row = c_RW'(i);
    end

    // Frame accumulation: hit count saturates at 2 (ghosting), first hit kept.
    always_comb begin
        w_base = (w_cidx == '0) ? 2'd0 : r_hits;
        w_hits = w_base;
        w_kc   = r_hc;
        w_kr   = r_hr;
        if (w_onehot) begin
            if (w_base == 2'd0) begin
                w_kc = w_cidx;
                w_kr = w_row;
            end
            if (w_base != 2'd2) w_hits = w_base + 2'd1;
        end
    end

    // Per-column sample registers, updated on each terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hits <= '0;
            r_hc   <= '0;
            r_hr   <= '0;
        end else if (w_tc) begin
            r_hits <= w_hits;
            r_hc   <= w_kc;
            r_hr   <= w_kr;
        end
    end

    generate
        if (MODO == 1) begin : g_map_tel
            // Legacy telephone map, indexed by {column, row}.
            always_comb begin
                w_code = '0;
                case ({w_kc, w_kr})
                    4'h0: w_code = 4'd15;
                    4'h1: w_code = 4'd1;
                    4'h2: w_code = 4'd4;
                    4'h3: w_code = 4'd7;
                    4'h4: w_code = 4'd0;
                    4'h5: w_code = 4'd2;
                    4'h6: w_code = 4'd5;
                    4'h7: w_code = 4'd8;
                    4'h8: w_code = 4'd14;
                    4'h9: w_code = 4'd3;
                    4'hA: w_code = 4'd6;
                    4'hB: w_code = 4'd9;
                    4'hC: w_code = 4'd13;
                    4'hD: w_code = 4'd10;
                    4'hE: w_code = 4'd11;
                    4'hF: w_code = 4'd12;
                    default: w_code = '0;
                endcase
            end
        end else begin : g_map_lin
            assign w_code = KW'(int'(w_kr) * N_COL + int'(w_kc));
        end
    endgenerate

    // Debounce FSM next-state, evaluated only at frame end.
    always_comb begin
        w_state_n  = r_state;
        w_cand_n   = r_cand;
        w_cnt_n    = r_cnt;
        w_rel_n    = r_rel;
        w_tecla_n  = r_tecla;
        w_valida_n = 1'b0;
        w_pres_n   = r_pres;
        w_cnt_inc  = (r_cnt == c_BW'(DEBOUNCE)) ? r_cnt : r_cnt + c_BW'(1);
        w_rel_inc  = (r_rel == c_BW'(DEBOUNCE)) ? r_rel : r_rel + c_BW'(1);
        if (w_fe) begin
            case (r_state)
                c_REPOSO: begin
                    if (w_key) begin
                        w_cand_n = w_code;
                        w_cnt_n  = c_BW'(1);
                        if (DEBOUNCE == 1) begin
                            w_tecla_n  = w_code;
                            w_valida_n = 1'b1;
                            w_pres_n   = 1'b1;
                            w_rel_n    = '0;
                            w_state_n  = c_PULSADA;
                        end else begin
                            w_state_n = c_CONFIRMA;
                        end
                    end
                end
                c_CONFIRMA: begin
                    if (w_key && (w_code == r_cand)) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc == c_BW'(DEBOUNCE)) begin
                            w_tecla_n  = w_code;
                            w_valida_n = 1'b1;
                            w_pres_n   = 1'b1;
                            w_rel_n    = '0;
                            w_cnt_n    = '0;
                            w_state_n  = c_PULSADA;
                        end
                    end else if (w_key) begin
                        w_cand_n = w_code;
                        w_cnt_n  = c_BW'(1);
                    end else begin
                        w_cnt_n   = '0;
                        w_state_n = c_REPOSO;
                    end
                end
                c_PULSADA: begin
                    if (w_key) begin
                        w_rel_n = '0;
                    end else begin
                        w_rel_n = w_rel_inc;
                        if (w_rel_inc == c_BW'(DEBOUNCE)) begin
                            w_rel_n   = '0;
                            w_pres_n  = 1'b0;
                            w_state_n = c_REPOSO;
                        end
                    end
                end
                default: w_state_n = c_REPOSO;
            endcase
        end
    end

    // Debounce FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_REPOSO;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_rel    <= '0;
            r_tecla  <= '0;
            r_valida <= 1'b0;
            r_pres   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cand   <= w_cand_n;
            r_cnt    <= w_cnt_n;
            r_rel    <= w_rel_n;
            r_tecla  <= w_tecla_n;
            r_valida <= w_valida_n;
            r_pres   <= w_pres_n;
        end
    end

    assign col        = r_col;
    assign tecla      = r_tecla;
    assign valida     = r_valida;
    assign presionada = r_pres;

endmodule
`default_nettype wire

// File: tb/tb_escaner_teclado.sv
`default_nettype none
// ============================================================================
// Module      : tb_escaner_teclado
// Description : Self-checking bench for escaner_teclado. Instance A is a 4x4
//               telephone-map keypad, instance B a 2x3 linear-map keypad.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_escaner_teclado;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic [15:0] keys_a = '0;   // bit c*4+r
    logic [5:0]  keys_b = '0;   // bit c*2+r

    logic [3:0] fil_a, col_a, tecla_a;
    logic       valida_a, pres_a;
    logic [1:0] fil_b;
    logic [2:0] col_b, tecla_b;
    logic       valida_b, pres_b;

    escaner_teclado #(.N_FIL(4), .N_COL(4), .SCAN_DIV(4), .DEBOUNCE(3), .MODO(1)) u_a (
        .clk(clk), .rst(rst_a), .fil(fil_a), .col(col_a),
        .tecla(tecla_a), .valida(valida_a), .presionada(pres_a)
    );

    escaner_teclado #(.N_FIL(2), .N_COL(3), .SCAN_DIV(4), .DEBOUNCE(3), .MODO(0)) u_b (
        .clk(clk), .rst(rst_b), .fil(fil_b), .col(col_b),
        .tecla(tecla_b), .valida(valida_b), .presionada(pres_b)
    );

    // Keypad model: a pressed key connects its column drive to its row line.
    always_comb begin
        fil_a = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys_a[c*4+r] && col_a[3-c]) fil_a[3-r] = 1'b1;
    end

    always_comb begin
        fil_b = '0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 2; r++)
                if (keys_b[c*2+r] && col_b[2-c]) fil_b[1-r] = 1'b1;
    end

    int total = 0;
    int bad   = 0;
    int pulses;
    int pulse_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_a(input logic [15:0] k, input int nfr);
        keys_a   = k;
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= nfr * 16; i++) begin
            @(negedge clk);
            if (valida_a) begin
                pulses++;
                pulse_at = i;
            end
        end
    endtask

    task automatic run_b(input logic [5:0] k, input int nfr);
        keys_b   = k;
        pulses   = 0;
        pulse_at = 0;
        for (int i = 1; i <= nfr * 12; i++) begin
            @(negedge clk);
            if (valida_b) begin
                pulses++;
                pulse_at = i;
            end
        end
    endtask

    typedef struct {
        string       tag;
        logic [15:0] keys;
        int          nfr;
        int          exp_pulses;
        int          exp_at;     // cycle of the strobe within the step, 0 = none
        int          exp_tecla;
        logic        exp_pres;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string t, input logic [15:0] k, input int n,
                                input int p, input int at, input int tc, input logic pr);
        vec_t v;
        v.tag = t; v.keys = k; v.nfr = n; v.exp_pulses = p;
        v.exp_at = at; v.exp_tecla = tc; v.exp_pres = pr;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Steps applied back-to-back to instance A, each starting on a frame boundary.
        tbl.push_back(mk("press_c0r1",   16'h0002, 6, 1, 48,  1, 1'b1));
        tbl.push_back(mk("rel_2fr",      16'h0000, 2, 0,  0,  1, 1'b1));
        tbl.push_back(mk("rel_3rd",      16'h0000, 1, 0,  0,  1, 1'b0));
        tbl.push_back(mk("bnc_off1",     16'h0000, 1, 0,  0,  1, 1'b0));
        tbl.push_back(mk("bnc_on1",      16'h0040, 1, 0,  0,  1, 1'b0));
        tbl.push_back(mk("bnc_off2",     16'h0000, 1, 0,  0,  1, 1'b0));
        tbl.push_back(mk("bnc_on2",      16'h0040, 1, 0,  0,  1, 1'b0));
        tbl.push_back(mk("bnc_off3",     16'h0000, 1, 0,  0,  1, 1'b0));
        tbl.push_back(mk("bnc_hold",     16'h0040, 3, 1, 48,  5, 1'b1));
        tbl.push_back(mk("bnc_rel",      16'h0000, 3, 0,  0,  5, 1'b0));
        tbl.push_back(mk("ghost_2col",   16'h1010, 5, 0,  0,  5, 1'b0));
        tbl.push_back(mk("ghost_samecol",16'h0600, 5, 0,  0,  5, 1'b0));
        tbl.push_back(mk("press_c2r3",   16'h0800, 4, 1, 48,  9, 1'b1));
        tbl.push_back(mk("change_held",  16'h1000, 5, 0,  0,  9, 1'b1));
        tbl.push_back(mk("rel_after_chg",16'h0000, 3, 0,  0,  9, 1'b0));
        tbl.push_back(mk("press_c3r0",   16'h1000, 3, 1, 48, 13, 1'b1));
        tbl.push_back(mk("rel_c3r0",     16'h0000, 3, 0,  0, 13, 1'b0));
        tbl.push_back(mk("cand_first",   16'h0001, 2, 0,  0, 13, 1'b0));
        tbl.push_back(mk("cand_restart", 16'h8000, 3, 1, 48, 12, 1'b1));
        tbl.push_back(mk("rel_final",    16'h0000, 3, 0,  0, 12, 1'b0));

        // Reset of instance A
        rst_a = 1'b1;
        repeat (3) @(negedge clk);
        check("a_rst_col",    col_a,    4'b1000);
        check("a_rst_tecla",  tecla_a,  0);
        check("a_rst_valida", valida_a, 0);
        check("a_rst_pres",   pres_a,   0);
        rst_a = 1'b0;

        // Column rotation, 4 cycles per column, one idle frame
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 3)  check("a_col_dwell", col_a, 4'b1000);
            if (i == 4)  check("a_col_1",     col_a, 4'b0100);
            if (i == 8)  check("a_col_2",     col_a, 4'b0010);
            if (i == 12) check("a_col_3",     col_a, 4'b0001);
            if (i == 16) check("a_col_wrap",  col_a, 4'b1000);
        end

        foreach (tbl[j]) begin
            run_a(tbl[j].keys, tbl[j].nfr);
            check({tbl[j].tag, "_pulses"}, pulses, tbl[j].exp_pulses);
            if (tbl[j].exp_at != 0) check({tbl[j].tag, "_latency"}, pulse_at, tbl[j].exp_at);
            check({tbl[j].tag, "_tecla"}, tecla_a, tbl[j].exp_tecla);
            check({tbl[j].tag, "_pres"},  pres_a,  tbl[j].exp_pres);
        end

        // Instance B: 2 rows x 3 columns, linear map
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        check("b_rst_col", col_b, 3'b100);
        rst_b = 1'b0;

        run_b(6'b100000, 3);               // r=1, c=2
        check("b_press_pulses",  pulses,   1);
        check("b_press_latency", pulse_at, 36);
        check("b_press_tecla",   tecla_b,  5);
        check("b_press_pres",    pres_b,   1);
        run_b(6'b000000, 3);
        check("b_rel_pres",      pres_b,   0);

        // Two confirming frames of r=0,c=1, then reset partway into the third
        run_b(6'b000100, 2);
        check("b_conf_pulses", pulses, 0);
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (valida_b) pulses++;
        end
        rst_b = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (valida_b) pulses++;
        end
        check("b_midrst_nostrobe", pulses,   0);
        check("b_midrst_col",      col_b,    3'b100);
        check("b_midrst_tecla",    tecla_b,  0);
        check("b_midrst_pres",     pres_b,   0);
        check("b_midrst_valida",   valida_b, 0);
        rst_b = 1'b0;

        // Debounce count must restart from zero after the reset
        run_b(6'b000100, 2);
        check("b_postrst_early", pulses, 0);
        run_b(6'b000100, 1);
        check("b_postrst_pulses",  pulses,   1);
        check("b_postrst_latency", pulse_at, 12);
        check("b_postrst_tecla",   tecla_b,  1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
